// File: rtl/ysyx_22041412_csr_pkg.sv
// ysyx_22041412_csr_pkg: shared encodings, CSR index map and FSM states for the CSR issue block
package ysyx_22041412_csr_pkg;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_PRIV = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;
    localparam logic [2:0] F3_ILL = 3'b100;
    localparam logic [11:0] FN_ECALL = 12'h000;
    localparam logic [11:0] FN_MRET = 12'h302;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC = 12'h305;
    localparam logic [11:0] CSR_MEPC = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [2:0] IDX_MRET = 3'd0;
    localparam logic [2:0] IDX_ECALL = 3'd1;
    localparam logic [2:0] IDX_MSTATUS = 3'd2;
    localparam logic [2:0] IDX_MTVEC = 3'd3;
    localparam logic [2:0] IDX_MEPC = 3'd4;
    localparam logic [2:0] IDX_MCAUSE = 3'd5;
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_REQ,
        S_ACK,
        S_ERR
    } state_e;
    function automatic logic [3:0] csr_map(input logic [11:0] num);
        return num == CSR_MSTATUS ? {1'b1, IDX_MSTATUS} :
               num == CSR_MTVEC   ? {1'b1, IDX_MTVEC}   :
               num == CSR_MEPC    ? {1'b1, IDX_MEPC}    :
               num == CSR_MCAUSE  ? {1'b1, IDX_MCAUSE}  : 4'b0;
    endfunction
endpackage

// File: rtl/ysyx_22041412_csr_decode.sv
// ysyx_22041412_csr_decode: classifies a system instruction into ecall, mret, CSR op or illegal
module ysyx_22041412_csr_decode
    import ysyx_22041412_csr_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        legal_o,
    output logic        is_ecall_o,
    output logic        is_mret_o,
    output logic [2:0]  addr_o,
    output logic        use_imm_o
);
    logic        sys;
    logic [2:0]  f3;
    logic [11:0] fn;
    logic [3:0]  map;
    // pure decode; func3=100 and unmapped CSR numbers fall out as illegal
    always_comb begin
        sys = inst_i[6:0] == OPC_SYSTEM;
        f3 = inst_i[14:12];
        fn = inst_i[31:20];
        map = csr_map(fn);
        is_ecall_o = sys && f3 == F3_PRIV && fn == FN_ECALL;
        is_mret_o = sys && f3 == F3_PRIV && fn == FN_MRET;
        legal_o = is_ecall_o || is_mret_o || (sys && f3 != F3_PRIV && f3 != F3_ILL && map[3]);
        addr_o = is_ecall_o ? IDX_ECALL : is_mret_o ? IDX_MRET : map[2:0];
        use_imm_o = f3[2];
    end
endmodule

// File: rtl/ysyx_22041412_csr_issue.sv
// ysyx_22041412_csr_issue: issues one CSR/ecall/mret request at a time and returns rd data or a redirect
module ysyx_22041412_csr_issue
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    output logic            csr_en,
    output logic [2:0]      csr_addr,
    output logic [2:0]      csr_func3,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_pc,
    output logic            csr_valid,
    input  logic            csr_ready_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            err
);
    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      addr_q, func3_q;
    logic [XLEN-1:0] wdata_q, pc_q, data_q;
    logic [4:0]      rd_q;
    logic            sys_q;
    logic            legal, is_ecall, is_mret, use_imm, take;
    logic [2:0]      dec_addr;

    ysyx_22041412_csr_decode u_decode (
        .inst_i    (in_inst),
        .legal_o   (legal),
        .is_ecall_o(is_ecall),
        .is_mret_o (is_mret),
        .addr_o    (dec_addr),
        .use_imm_o (use_imm)
    );

    assign take = state_q == S_IDLE && !csr_ready_i && in_valid && legal;

    // state and timeout counter registers
    always_ff @(posedge clk) begin
        state_q <= rst ? S_IDLE : state_d;
        cnt_q <= rst ? 8'd0 : cnt_d;
    end

    // next state; a ready seen while idle is stale and must be cleared before new traffic
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                state_d = csr_ready_i ? S_DRAIN : !in_valid ? S_IDLE : legal ? S_REQ : S_ERR;
            end
            S_REQ: begin
                cnt_d = csr_ready_i ? cnt_q : cnt_q + 8'd1;
                state_d = csr_ready_i ? S_ACK : cnt_d == 8'(TIMEOUT) ? S_ERR : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // handshake and pulse outputs decoded from the current state
    always_comb begin
        in_ready = state_q == S_IDLE && !csr_ready_i;
        csr_en = state_q == S_REQ || state_q == S_ACK;
        csr_valid = state_q == S_DRAIN || state_q == S_ACK;
        wb_we = state_q == S_ACK && !sys_q && rd_q != 5'd0;
        redir_valid = state_q == S_ACK && sys_q;
        err = state_q == S_ERR;
    end

    // request fields latched at accept, response data captured on ready in REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            pc_q <= '0;
            rd_q <= '0;
            sys_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (take) begin
                addr_q <= dec_addr;
                func3_q <= in_inst[14:12];
                wdata_q <= use_imm ? {{(XLEN-5){1'b0}}, in_inst[19:15]} : in_rs1;
                pc_q <= in_pc;
                rd_q <= in_inst[11:7];
                sys_q <= is_ecall || is_mret;
            end
            if (state_q == S_REQ && csr_ready_i) data_q <= csr_rdata_i;
        end
    end

    assign csr_addr = addr_q;
    assign csr_func3 = func3_q;
    assign csr_wdata = wdata_q;
    assign csr_pc = pc_q;
    assign wb_rd = rd_q;
    assign wb_data = data_q;
    assign redir_pc = data_q;
endmodule

// File: tb/tb_ysyx_22041412_csr_issue.sv
// tb_ysyx_22041412_csr_issue: scoreboard bench with a CSR file stub and a behavioural CSR model
module tb_ysyx_22041412_csr_issue;
    localparam logic [2:0] K_WB = 3'b100, K_RD = 3'b010, K_ER = 3'b001;
    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0, in_rs1 = '0;
    logic csr_ready_i = 1'b0;
    logic [63:0] csr_rdata_i = '0;
    logic in_ready, csr_en, csr_valid, wb_we, redir_valid, err;
    logic [2:0] csr_addr, csr_func3;
    logic [63:0] csr_wdata, csr_pc, wb_data, redir_pc;
    logic [4:0] wb_rd;

    int n_chk = 0, n_fail = 0;
    exp_t sb[$];
    logic [63:0] s_csr [2:5] = '{64'ha_0000_1800, 64'h0, 64'h0, 64'h0};
    logic [63:0] m_csr [2:5] = '{64'ha_0000_1800, 64'h0, 64'h0, 64'h0};
    logic stub_dead = 1'b0;
    int stub_pct = 40;

    always #5 clk = ~clk;

    ysyx_22041412_csr_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_rs1(in_rs1), .csr_en(csr_en), .csr_addr(csr_addr),
        .csr_func3(csr_func3), .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_valid(csr_valid),
        .csr_ready_i(csr_ready_i), .csr_rdata_i(csr_rdata_i), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .redir_valid(redir_valid), .redir_pc(redir_pc), .err(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // CSR file stub: captures after a random delay, commits only on en & valid
    always @(posedge clk) begin
        if (csr_valid && csr_ready_i) begin
            csr_ready_i <= 1'b0;
            if (csr_en && csr_addr == 3'd1) begin
                s_csr[4] <= csr_pc;
                s_csr[5] <= 64'hb;
            end else if (csr_en && csr_addr >= 3'd2 && csr_addr <= 3'd5) begin
                case (csr_func3[1:0])
                    2'd1: s_csr[csr_addr] <= csr_wdata;
                    2'd2: s_csr[csr_addr] <= s_csr[csr_addr] | csr_wdata;
                    2'd3: s_csr[csr_addr] <= s_csr[csr_addr] & ~csr_wdata;
                    default: ;
                endcase
            end
        end else if (csr_en && !csr_ready_i && !stub_dead && $urandom_range(99) < stub_pct) begin
            csr_ready_i <= 1'b1;
            csr_rdata_i <= csr_addr == 3'd1 ? s_csr[3] : csr_addr == 3'd0 ? s_csr[4] :
                           (csr_addr <= 3'd5) ? s_csr[csr_addr] : 64'hx;
        end
    end

    // monitor: every result pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (wb_we || redir_valid || err)) begin
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_kind", {wb_we, redir_valid, err}, e.kind);
                if (e.kind == K_WB) begin
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                end
                if (e.kind == K_RD) chk("redir_pc", redir_pc, e.data);
            end
        end
    end

    function automatic int csr_idx(input logic [11:0] n);
        return n == 12'h300 ? 2 : n == 12'h305 ? 3 : n == 12'h341 ? 4 : n == 12'h342 ? 5 : -1;
    endfunction

    function automatic logic [31:0] mk(input logic [11:0] c, input logic [4:0] s, input logic [2:0] f, input logic [4:0] d);
        return {c, s, f, d, 7'h73};
    endfunction

    // architectural model: mode 0 normal, 1 expect error only, 2 expect nothing
    task automatic model(input logic [31:0] inst, input logic [63:0] rs1, input logic [63:0] pc, input int mode);
        logic [2:0] f3;
        logic [11:0] fn;
        logic [63:0] src, old;
        int ix;
        f3 = inst[14:12];
        fn = inst[31:20];
        ix = csr_idx(fn);
        src = f3[2] ? {59'b0, inst[19:15]} : rs1;
        if (mode == 1) sb.push_back('{K_ER, 5'd0, 64'd0});
        else if (mode == 2) ;
        else if (inst[6:0] != 7'h73) sb.push_back('{K_ER, 5'd0, 64'd0});
        else if (f3 == 3'd0 && fn == 12'h000) begin
            sb.push_back('{K_RD, 5'd0, m_csr[3]});
            m_csr[4] = pc;
            m_csr[5] = 64'hb;
        end else if (f3 == 3'd0 && fn == 12'h302) sb.push_back('{K_RD, 5'd0, m_csr[4]});
        else if (f3 == 3'd0 || f3 == 3'd4 || ix < 0) sb.push_back('{K_ER, 5'd0, 64'd0});
        else begin
            old = m_csr[ix];
            m_csr[ix] = f3[1:0] == 2'd1 ? src : f3[1:0] == 2'd2 ? old | src : old & ~src;
            if (inst[11:7] != 5'd0) sb.push_back('{K_WB, inst[11:7], old});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", in_ready, 1);
    endtask

    // called at a negedge; returns at the negedge right after the accepting edge
    task automatic issue(input logic [31:0] inst, input logic [63:0] rs1, input logic [63:0] pc, input int mode);
        wait_idle();
        model(inst, rs1, pc, mode);
        in_valid = 1'b1;
        in_inst = inst;
        in_rs1 = rs1;
        in_pc = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, r;
        logic [11:0] c;
        logic [2:0] f;
        logic [31:0] w;
        logic [11:0] lst [6];
        lst = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7c0};
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {in_ready, csr_en, csr_valid, wb_we, redir_valid, err, csr_addr, csr_func3, wb_rd}, {1'b1, 16'd0});
        chk("rst_data", csr_wdata | csr_pc | wb_data | redir_pc, 0);
        rst = 1'b0;
        @(negedge clk);
        issue(mk(12'h305, 5'd1, 3'b001, 5'd5), 64'h8000_0100, 64'h8000_0000, 0);
        chk("t1_req", {csr_en, csr_valid, csr_addr, csr_func3}, {2'b10, 3'd3, 3'b001});
        chk("t1_wdata", csr_wdata, 64'h8000_0100);
        @(negedge clk);
        chk("t1_hold", {csr_addr, csr_func3}, {3'd3, 3'b001});
        wait_idle();
        chk("t1_mtvec", s_csr[3], 64'h8000_0100);
        issue(mk(12'h300, 5'd3, 3'b110, 5'd6), 64'hdead_beef, 64'h0, 0);
        chk("t2_wdata", csr_wdata, 64'd3);
        wait_idle();
        chk("t2_mstatus", s_csr[2], 64'ha_0000_1803);
        issue(mk(12'h000, 5'd0, 3'b000, 5'd0), 64'h1234, 64'h8000_0040, 0);
        chk("t3_ecall_req", {csr_addr, csr_func3}, {3'd1, 3'd0});
        chk("t3_pc", csr_pc, 64'h8000_0040);
        wait_idle();
        chk("t3_mepc", s_csr[4], 64'h8000_0040);
        chk("t3_mcause", s_csr[5], 64'hb);
        issue(mk(12'h302, 5'd0, 3'b000, 5'd0), 64'h0, 64'h8000_0200, 0);
        chk("t3_mret_addr", csr_addr, 0);
        wait_idle();
        issue(mk(12'h344, 5'd1, 3'b001, 5'd7), 64'h55, 64'h0, 0);
        chk("t4_err", {err, csr_en, csr_valid}, 3'b100);
        @(negedge clk);
        chk("t4_ready", {in_ready, csr_en}, 2'b10);
        stub_dead = 1'b1;
        issue(mk(12'h305, 5'd1, 3'b001, 5'd8), 64'h77, 64'h0, 1);
        n = 0;
        k = 0;
        while (!err && k < 400) begin
            if (csr_en) n++;
            @(negedge clk);
            k++;
        end
        chk("t5_err_en", {err, csr_en}, 2'b10);
        chk("t5_req_cycles", n, 255);
        stub_dead = 1'b0;
        wait_idle();
        stub_pct = 100;
        issue(mk(12'h342, 5'd1, 3'b001, 5'd9), 64'h99, 64'h0, 2);
        k = 0;
        while (!csr_ready_i && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_stale", {csr_en, csr_ready_i}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_drain", {csr_valid, csr_en, in_ready}, 3'b100);
        @(negedge clk);
        chk("t6_idle", {in_ready, csr_ready_i}, 2'b10);
        issue(mk(12'h342, 5'd2, 3'b001, 5'd10), 64'h4242, 64'h0, 0);
        wait_idle();
        for (int i = 0; i < 200; i++) begin
            stub_pct = $urandom_range(100, 20);
            r = $urandom_range(15);
            c = lst[$urandom_range(5)];
            f = 3'($urandom_range(7));
            w = r == 0 ? mk(12'h000, 5'd0, 3'd0, 5'd0) : r == 1 ? mk(12'h302, 5'd0, 3'd0, 5'd0) :
                mk(c, 5'($urandom), f, 5'($urandom));
            if (r == 2) w[6:0] = 7'h33;
            issue(w, {$urandom, $urandom}, {$urandom, $urandom} & ~64'h3, 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        for (int i = 2; i <= 5; i++) chk($sformatf("csr_final_%0d", i), s_csr[i], m_csr[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
